// File: rtl/gumnut_pkg.sv
// Shared Gumnut definitions: PC width, next-PC operation codes and the
// sequencer state encoding.
package gumnut_pkg;

    localparam int PC_W = 12;

    localparam logic [3:0] PCOP_INC = 4'b0000;
    localparam logic [3:0] PCOP_BZ  = 4'b0100;
    localparam logic [3:0] PCOP_BNZ = 4'b0101;
    localparam logic [3:0] PCOP_BC  = 4'b0110;
    localparam logic [3:0] PCOP_BNC = 4'b0111;
    localparam logic [3:0] PCOP_JMP = 4'b1000;
    localparam logic [3:0] PCOP_RET = 4'b1010;
    localparam logic [3:0] PCOP_ISR = 4'b1100;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WRITE = 3'd3,
        ST_INT   = 3'd4
    } seq_state_e;

    // Branch opcodes carry the condition field in their two low bits.
    function automatic logic [3:0] branch_oper(input logic [1:0] cond);
        return {2'b01, cond};
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address LIFO: a full push overwrites the oldest entry,
// an empty pop reads zero; both raise the sticky error flag.
module return_stack
    import gumnut_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             err_q, err_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign top_o   = empty_o ? 12'h000 : mem_q[wp_q - PTR_ONE];
    assign err_o   = err_q;

    // Pointer, occupancy and error next-state; push wins if both are asserted.
    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (push_i) begin
            wp_d = wp_q + PTR_ONE;
            if (full_o) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop_i) begin
            if (empty_o) begin
                err_d = 1'b1;
            end else begin
                wp_d  = wp_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage; contents are never visible while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wp_q] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Gumnut fetch/execute/write-back sequencer owning the PC and return stack.
// Define PC_SEQ_INT_EN to build the interrupt path (INT state and int_en).
module pc_sequencer
    import gumnut_pkg::*;
#(
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] ISR_ADDR    = 12'h001
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            imem_ack_i,
    input  logic            is_branch_i,
    input  logic            is_jump_i,
    input  logic            is_jsb_i,
    input  logic            is_ret_i,
    input  logic            is_reti_i,
    input  logic            is_enai_i,
    input  logic            is_disi_i,
    input  logic            is_mem_i,
    input  logic [1:0]      branch_cond_i,
    input  logic            dmem_ack_i,
    input  logic            int_req_i,
    input  logic [PC_W-1:0] npc_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] pc_o,
    output logic [3:0]      pc_oper_o,
    output logic [PC_W-1:0] stack_addr_o,
    output logic [PC_W-1:0] isr_addr_o,
    output logic            reg_we_o,
    output logic            int_ack_o,
    output logic            stack_err_o
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic            push_s, pop_s;
    logic [PC_W-1:0] push_data_s;
    logic            int_take_s;
    logic            stk_full_s, stk_empty_s;

`ifdef PC_SEQ_INT_EN
    logic int_en_q, int_en_d;
    assign int_take_s = int_en_q && int_req_i && !is_reti_i;
`else
    assign int_take_s = 1'b0;
`endif

    assign pc_o       = pc_q;
    assign isr_addr_o = ISR_ADDR;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory handshakes stall in place.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = imem_ack_i ? ST_EXEC : ST_FETCH;
            ST_EXEC:  state_d = is_mem_i ? ST_MEM : ST_WRITE;
            ST_MEM:   state_d = dmem_ack_i ? ST_WRITE : ST_MEM;
            ST_WRITE: state_d = int_take_s ? ST_INT : ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Outputs and stack strobes; interrupt entry pushes the already-updated PC.
    always_comb begin
        imem_req_o  = 1'b0;
        reg_we_o    = 1'b0;
        int_ack_o   = 1'b0;
        pc_oper_o   = PCOP_INC;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_data_s = pc_q + 12'h001;
        case (state_q)
            ST_FETCH: imem_req_o = 1'b1;
            ST_WRITE: begin
                reg_we_o = !(is_branch_i || is_jump_i || is_jsb_i || is_ret_i || is_reti_i);
                if (is_ret_i || is_reti_i) begin
                    pc_oper_o = PCOP_RET;
                    pop_s     = 1'b1;
                end else if (is_jump_i || is_jsb_i) begin
                    pc_oper_o = PCOP_JMP;
                    push_s    = is_jsb_i;
                end else if (is_branch_i) begin
                    pc_oper_o = branch_oper(branch_cond_i);
                end else begin
                    pc_oper_o = PCOP_INC;
                end
            end
`ifdef PC_SEQ_INT_EN
            ST_INT: begin
                int_ack_o   = 1'b1;
                pc_oper_o   = PCOP_ISR;
                push_s      = 1'b1;
                push_data_s = pc_q;
            end
`endif
            default: imem_req_o = 1'b0;
        endcase
    end

    // PC register: loads the next-PC unit result on WRITE and INT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= 12'h000;
        end else if (state_q == ST_WRITE || state_q == ST_INT) begin
            pc_q <= npc_i;
        end else begin
            pc_q <= pc_q;
        end
    end

`ifdef PC_SEQ_INT_EN
    // Interrupt enable: reti/enai set, disi and interrupt entry clear.
    always_comb begin
        int_en_d = int_en_q;
        if (state_q == ST_WRITE) begin
            if (is_reti_i || is_enai_i) begin
                int_en_d = 1'b1;
            end else if (is_disi_i) begin
                int_en_d = 1'b0;
            end else begin
                int_en_d = int_en_q;
            end
        end else if (state_q == ST_INT) begin
            int_en_d = 1'b0;
        end else begin
            int_en_d = int_en_q;
        end
    end

    // Interrupt enable register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_en_q <= 1'b0;
        end else begin
            int_en_q <= int_en_d;
        end
    end
`endif

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (push_data_s),
        .top_o   (stack_addr_o),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s),
        .err_o   (stack_err_o)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random
// instruction streams checked against an instruction-level reference model.
module tb_pc_sequencer;

    localparam int          DEPTH = 8;
    localparam logic [11:0] ISR   = 12'h001;
`ifdef PC_SEQ_INT_EN
    localparam bit INT_BUILT = 1'b1;
`else
    localparam bit INT_BUILT = 1'b0;
`endif

    typedef enum int {K_ADD, K_LDM, K_BR, K_JMP, K_JSB, K_RET, K_RETI, K_ENAI, K_DISI} kind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, int_req = 1'b0;
    logic        is_branch = 1'b0, is_jump = 1'b0, is_jsb = 1'b0, is_ret = 1'b0;
    logic        is_reti = 1'b0, is_enai = 1'b0, is_disi = 1'b0, is_mem = 1'b0;
    logic [1:0]  cond = 2'b00;
    logic [11:0] npc;
    logic        imem_req, reg_we, int_ack, stack_err;
    logic [11:0] pc, stack_addr, isr_addr;
    logic [3:0]  pc_oper;

    // Next-PC unit stand-in.
    logic        br_taken = 1'b0;
    logic [11:0] tgt = 12'h000;

    // Reference model state.
    logic [11:0] m_pc;
    logic [11:0] m_stack[$];
    logic        m_err;
    logic        m_int_en;
    int          ntests = 0;
    int          nfail  = 0;

    pc_sequencer #(.STACK_DEPTH(DEPTH), .ISR_ADDR(ISR)) dut (
        .clk_i(clk), .rst_i(rst), .imem_ack_i(imem_ack),
        .is_branch_i(is_branch), .is_jump_i(is_jump), .is_jsb_i(is_jsb),
        .is_ret_i(is_ret), .is_reti_i(is_reti), .is_enai_i(is_enai),
        .is_disi_i(is_disi), .is_mem_i(is_mem), .branch_cond_i(cond),
        .dmem_ack_i(dmem_ack), .int_req_i(int_req), .npc_i(npc),
        .imem_req_o(imem_req), .pc_o(pc), .pc_oper_o(pc_oper),
        .stack_addr_o(stack_addr), .isr_addr_o(isr_addr), .reg_we_o(reg_we),
        .int_ack_o(int_ack), .stack_err_o(stack_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (pc_oper)
            4'b0100, 4'b0101, 4'b0110, 4'b0111: npc = br_taken ? tgt : pc + 12'h001;
            4'b1000: npc = tgt;
            4'b1010: npc = stack_addr;
            4'b1100: npc = isr_addr;
            default: npc = pc + 12'h001;
        endcase
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_push(input logic [11:0] v);
        if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_err = 1'b1;
        end
        m_stack.push_back(v);
    endtask

    task automatic m_pop(output logic [11:0] v);
        if (m_stack.size() == 0) begin
            v = 12'h000;
            m_err = 1'b1;
        end else begin
            v = m_stack.pop_back();
        end
    endtask

    task automatic m_reset;
        m_pc = 12'h000;
        m_stack.delete();
        m_err = 1'b0;
        m_int_en = 1'b0;
    endtask

    task automatic set_decode(input kind_e k);
        is_branch = (k == K_BR);
        is_jump   = (k == K_JMP);
        is_jsb    = (k == K_JSB);
        is_ret    = (k == K_RET);
        is_reti   = (k == K_RETI);
        is_enai   = (k == K_ENAI);
        is_disi   = (k == K_DISI);
        is_mem    = (k == K_LDM);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        int_req = 1'b0;
        set_decode(K_ADD);
        tick;
        tick;
        rst = 1'b0;
        m_reset();
        #1;
    endtask

    // One instruction: fetch (with stalls), exec, optional mem, write, optional INT.
    task automatic run_instr(input kind_e k, input logic [1:0] c, input logic zero,
                             input logic carry, input logic [11:0] t,
                             input int iw, input int dw, input logic ireq);
        logic [11:0] e_top, e_oper, nxt;
        logic        e_we, take;
        set_decode(k);
        cond = c;
        tgt = t;
        case (c)
            2'b00:   br_taken = zero;
            2'b01:   br_taken = !zero;
            2'b10:   br_taken = carry;
            default: br_taken = !carry;
        endcase
        int_req = 1'($urandom_range(0, 1));
        imem_ack = 1'b0;
        #1;
        check("fetch_req", {11'h000, imem_req}, 12'h001);
        check("fetch_pc", pc, m_pc);
        check("fetch_we", {11'h000, reg_we}, 12'h000);
        for (int i = 0; i < iw; i++) begin
            tick;
            check("istall_pc", pc, m_pc);
            check("istall_req", {11'h000, imem_req}, 12'h001);
        end
        imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        check("exec_req", {11'h000, imem_req}, 12'h000);
        check("exec_oper", {8'h00, pc_oper}, 12'h000);
        tick;
        if (k == K_LDM) begin
            for (int i = 0; i < dw; i++) begin
                check("dstall_we", {11'h000, reg_we}, 12'h000);
                check("dstall_pc", pc, m_pc);
                tick;
            end
            dmem_ack = 1'b1;
            tick;
            dmem_ack = 1'b0;
        end
        int_req = ireq;
        #1;
        e_top  = (m_stack.size() > 0) ? m_stack[$] : 12'h000;
        e_we   = (k == K_ADD || k == K_LDM || k == K_ENAI || k == K_DISI);
        case (k)
            K_BR:          e_oper = {10'h001, c};
            K_JMP, K_JSB:  e_oper = 12'h008;
            K_RET, K_RETI: e_oper = 12'h00A;
            default:       e_oper = 12'h000;
        endcase
        check("wr_oper", {8'h00, pc_oper}, e_oper);
        check("wr_we", {11'h000, reg_we}, {11'h000, e_we});
        check("wr_top", stack_addr, e_top);
        take = INT_BUILT && m_int_en && ireq && (k != K_RETI);
        case (k)
            K_BR:          nxt = br_taken ? t : m_pc + 12'h001;
            K_JMP:         nxt = t;
            K_JSB:         begin m_push(m_pc + 12'h001); nxt = t; end
            K_RET, K_RETI: m_pop(nxt);
            default:       nxt = m_pc + 12'h001;
        endcase
        m_pc = nxt;
        if (INT_BUILT) begin
            if (k == K_RETI || k == K_ENAI) m_int_en = 1'b1;
            else if (k == K_DISI) m_int_en = 1'b0;
        end
        tick;
        if (take) begin
            check("int_ack", {11'h000, int_ack}, 12'h001);
            check("int_oper", {8'h00, pc_oper}, 12'h00C);
            check("int_pc", pc, m_pc);
            m_push(m_pc);
            m_pc = ISR;
            m_int_en = 1'b0;
            tick;
        end
        check("end_pc", pc, m_pc);
        check("end_err", {11'h000, stack_err}, {11'h000, m_err});
        check("end_ack", {11'h000, int_ack}, 12'h000);
    endtask

    initial begin
        m_reset();
        do_reset();
        check("rst_pc", pc, 12'h000);
        check("rst_req", {11'h000, imem_req}, 12'h001);
        check("rst_oper", {8'h00, pc_oper}, 12'h000);
        check("rst_we", {11'h000, reg_we}, 12'h000);
        check("rst_ack", {11'h000, int_ack}, 12'h000);
        check("rst_err", {11'h000, stack_err}, 12'h000);
        check("rst_top", stack_addr, 12'h000);
        check("isr_addr", isr_addr, ISR);

        // Straight-line code up to PC 5, then bz taken and not taken.
        for (int i = 0; i < 5; i++) run_instr(K_ADD, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b0);
        run_instr(K_BR, 2'b00, 1'b1, 1'b0, 12'h0A0, 0, 0, 1'b0);
        check("bz_taken", pc, 12'h0A0);
        run_instr(K_BR, 2'b00, 1'b0, 1'b0, 12'h0F0, 0, 0, 1'b0);
        check("bz_not", pc, 12'h0A1);

        // Subroutine call and return.
        run_instr(K_JMP, 2'b00, 1'b0, 1'b0, 12'h010, 0, 0, 1'b0);
        run_instr(K_JSB, 2'b00, 1'b0, 1'b0, 12'h200, 0, 0, 1'b0);
        check("jsb_top", stack_addr, 12'h011);
        run_instr(K_RET, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b0);
        check("ret_pc", pc, 12'h011);

        // Overflow on the ninth push, underflow after reset.
        for (int i = 0; i < 9; i++) run_instr(K_JSB, 2'b00, 1'b0, 1'b0, 12'h300 + 12'(i), 0, 0, 1'b0);
        check("ovf_err", {11'h000, stack_err}, 12'h001);
        do_reset();
        run_instr(K_RET, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b0);
        check("unf_err", {11'h000, stack_err}, 12'h001);
        check("unf_pc", pc, 12'h000);

        // Interrupt during an add at 0x020, then reti.
        run_instr(K_ENAI, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b0);
        run_instr(K_JMP, 2'b00, 1'b0, 1'b0, 12'h020, 0, 0, 1'b0);
        run_instr(K_ADD, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b1);
        check("isr_pc", pc, INT_BUILT ? ISR : 12'h021);
        run_instr(K_RETI, 2'b00, 1'b0, 1'b0, 12'h000, 0, 0, 1'b1);
        check("reti_pc", pc, INT_BUILT ? 12'h021 : 12'h000);
        run_instr(K_LDM, 2'b00, 1'b0, 1'b0, 12'h000, 1, 2, 1'b0);

        // Fetch stall, then reset while stalled in MEM.
        run_instr(K_JSB, 2'b00, 1'b0, 1'b0, 12'h400, 0, 0, 1'b0);
        set_decode(K_LDM);
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_pc", pc, 12'h400);
            check("hold_req", {11'h000, imem_req}, 12'h001);
        end
        imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        tick;
        tick;
        check("mem_hold_pc", pc, 12'h400);
        check("mem_hold_we", {11'h000, reg_we}, 12'h000);
        check("mem_hold_req", {11'h000, imem_req}, 12'h000);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_reset();
        check("mrst_pc", pc, 12'h000);
        check("mrst_req", {11'h000, imem_req}, 12'h001);
        check("mrst_top", stack_addr, 12'h000);

        // Random instruction stream.
        for (int n = 0; n < 200; n++) begin
            run_instr(kind_e'($urandom_range(0, 8)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      12'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer that owns the 12-bit program counter of the Gumnut core and drives the next-PC selector's operation code each instruction. It runs the fetch/execute/write-back FSM, stalls on instruction and data memory handshakes, and keeps the return-address stack. It also handles interrupt entry and exit. It sits between the decoder and the next-PC unit: it supplies `pc_oper_o`/`stack_addr_o` and registers the returned `npc_i` as the new PC.

## Interface
- `STACK_DEPTH`, 8: return-stack entries; power of two, 2..16.
- `ISR_ADDR`, 12'h001: fixed interrupt vector, driven on `isr_addr_o`.
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `imem_ack_i` in 1: instruction word valid for the current `pc_o`.
- `is_branch_i`, `is_jump_i`, `is_jsb_i`, `is_ret_i`, `is_reti_i`, `is_enai_i`, `is_disi_i`, `is_mem_i` in 1 each: decoded instruction class, valid while in EXEC.
- `branch_cond_i` in 2: 00 bz, 01 bnz, 10 bc, 11 bnc.
- `dmem_ack_i` in 1: data access complete.
- `int_req_i` in 1: level interrupt request.
- `npc_i` in 12: next PC from the next-PC unit.
- `imem_req_o` out 1: fetch request.
- `pc_o` out 12: current PC.
- `pc_oper_o` out 4: next-PC operation code.
- `stack_addr_o` out 12: top-of-stack entry.
- `isr_addr_o` out 12: equals `ISR_ADDR`.
- `reg_we_o` out 1: register-file write strobe.
- `int_ack_o` out 1: one-cycle pulse on interrupt entry.
- `stack_err_o` out 1: sticky stack overflow/underflow flag.

## Operation
- States: FETCH, EXEC, MEM, WRITE.
- FETCH: `imem_req_o`=1. Stay until `imem_ack_i`, then go to EXEC.
- EXEC: if `is_mem_i`, go to MEM; otherwise go to WRITE.
- MEM: stay until `dmem_ack_i`, then go to WRITE.
- WRITE:
  - `pc_o` <= `npc_i`.
  - `reg_we_o`=1 unless the instruction is branch/jump/jsb/ret/reti.
  - Next state is FETCH.
- `pc_oper_o` is combinational from the WRITE-state decode and is 4'b0000 outside WRITE. Priority in WRITE:
  - Interrupt taken: 4'b1100.
  - ret/reti: 4'b1010.
  - jump/jsb: 4'b1000.
  - branch: {2'b01, `branch_cond_i`}.
  - otherwise: 4'b0000.
- Interrupt taken = `int_en` && `int_req_i` in WRITE, and the current instruction is not reti.
  - On a taken interrupt, the current instruction's own control transfer is completed first by pushing its computed successor, not PC+1.
  - Implementation: two-step. First WRITE a normal update. Then one extra INT cycle (a fifth state) with `pc_oper_o`=4'b1100, push of the updated `pc_o`, `int_en` <= 0, `int_ack_o`=1. Then FETCH.
- jsb: push `pc_o`+1 (12-bit wrap) in WRITE.
- ret: pop in WRITE.
- reti: pop and set `int_en` <= 1.
- enai sets `int_en`; disi clears it.
- Return stack: circular buffer plus a count.
  - Push when full: overwrite oldest entry, set `stack_err_o`.
  - Pop when empty: `stack_addr_o` reads 12'h000, count stays 0, set `stack_err_o`.

## Timing
- Reset values:
  - State FETCH.
  - `pc_o`=12'h000, `pc_oper_o`=0, `reg_we_o`=0, `int_ack_o`=0, `stack_err_o`=0.
  - `int_en`=0, stack count 0.
  - `imem_req_o`=1 in the first cycle after reset.
- Latency with zero-wait memories:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, WRITE).
  - Memory instruction: 4 cycles.
  - Taken interrupt adds 1 cycle.
- `imem_ack_i` or `dmem_ack_i` held low stalls indefinitely; all outputs stay stable.
- `rst_i` mid-instruction aborts at the next edge. No push/pop or PC write completes in that cycle.
- `int_req_i` is sampled only in WRITE. Requests arriving in other states wait.

## Configuration
- `PC_SEQ_INT_EN` defined: interrupt path, INT state, and `int_en` are present as above.
- `PC_SEQ_INT_EN` undefined:
  - `int_req_i` is ignored; `int_ack_o` is tied 0; the INT state is not built.
  - reti behaves exactly as ret; enai/disi are no-ops.

## Structure
- Shared package `gumnut_pkg` holds:
  - the 4-bit pc_oper encodings as named constants (INC, BZ, BNZ, BC, BNC, JMP, ISR, RET);
  - the state enum;
  - PC width 12.
- Sub-module `return_stack`: parameterised circular LIFO with push/pop/top/full/empty and error outputs.

## Test plan
- Reset, then straight-line code with immediate acks: `pc_o` steps 0→1→2 every 3 cycles; `reg_we_o` pulses once per instruction.
- bz at PC 5 with zero=1: `pc_oper_o`=4'b0100 in WRITE, `pc_o` takes `npc_i`. With zero=0, `pc_oper_o` is still 4'b0100 and the next-PC unit returns 6.
- jsb at 0x010 to 0x200, then ret: 0x011 is pushed; ret gives `pc_oper_o`=4'b1010, `stack_addr_o`=0x011, `pc_o`=0x011.
- Nine jsb with `STACK_DEPTH`=8: `stack_err_o` rises on the ninth push. A ret on an empty stack also sets the flag and gives `stack_addr_o`=0.
- enai, then `int_req_i`=1 during an add at 0x020: WRITE gives `pc_o`=0x021, then INT gives `int_ack_o` pulse, `pc_oper_o`=4'b1100, `pc_o`=0x001. reti returns to 0x021 and re-enables `int_en`.
- `imem_ack_i` held low for 5 cycles, then `rst_i` asserted during MEM: the FSM holds, then returns to FETCH with `pc_o`=0 and the stack empty.
